// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: operation codes and
// controller states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/addsub_n.sv
// WIDTH-bit adder/subtractor: sub inverts b and injects the carry-in, so
// cout=1 on subtract means no borrow.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   total;

  assign b_x   = b ^ {WIDTH{sub}};
  assign total = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
  assign cout  = total[WIDTH];
  assign sum   = total[WIDTH-1:0];

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned add/sub/multiply/divide with start/busy/done handshake.
// MUL is shift-add and DIV is restoring, one iteration per clock.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               cout_q, cout_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_sub, add_cout;
  logic [WIDTH-1:0]   trial_sum;
  logic               trial_cout;
  logic [2*WIDTH-1:0] div_shift, div_next, mul_next, step;
  logic [WIDTH:0]     mul_hi;
  logic               no_borrow;

  // Shared adder: operands straight from the ports while idle (ADD/SUB
  // finish in the accept cycle), accumulator high half while multiplying.
  always_comb begin
    add_a   = acc_q[2*WIDTH-1:WIDTH];
    add_b   = a_q;
    add_sub = 1'b0;
    if (state_q == IDLE) begin
      add_a   = a;
      add_b   = b;
      add_sub = (op == OP_SUB);
    end
  end

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign div_shift = {acc_q[2*WIDTH-2:0], 1'b0};

  addsub_n #(.WIDTH(WIDTH)) u_trial (
    .a    (div_shift[2*WIDTH-1:WIDTH]),
    .b    (b_q),
    .sub  (1'b1),
    .sum  (trial_sum),
    .cout (trial_cout)
  );

  // The bit shifted out of the remainder makes it at least 2^WIDTH > b.
  assign no_borrow = acc_q[2*WIDTH-1] | trial_cout;
  assign div_next  = no_borrow ? {trial_sum, div_shift[WIDTH-1:1], 1'b1} : div_shift;
  assign mul_hi    = acc_q[0] ? {add_cout, add_sum} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_next  = {mul_hi, acc_q[WIDTH-1:1]};
  assign step      = (op_q == OP_MUL) ? mul_next : div_next;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          cout_d = 1'b0;
          dbz_d  = 1'b0;
          unique case (op)
            OP_ADD, OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, add_sum};
              cout_d   = add_cout;
              state_d  = DONE;
            end
            OP_MUL: begin
              acc_d   = {{WIDTH{1'b0}}, b};
              state_d = RUN;
            end
            default: begin
              if (b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                dbz_d    = 1'b1;
                state_d  = DONE;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a};
                state_d = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        acc_d = step;
        if (cnt_q == LAST_CNT) begin
          result_d = step;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, multi-cycle successor to the 4-bit combinational add/subtract/shift arithmetic blocks.
- Performs unsigned add, subtract, full multiply (shift-add) and divide (restoring) on WIDTH-bit operands.
- Uses a start/busy/done handshake.
- Sits between the operand registers and the result bus of the ALU datapath. Replaces the fixed shift-by-constant multiply/divide with true iterative operations.

Parameters:
WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
a  in  WIDTH  operand A (minuend / multiplicand / dividend)
b  in  WIDTH  operand B (subtrahend / multiplier / divisor)
busy  out  1  high from the cycle after accept until done deasserts
done  out  1  one-cycle pulse; result valid
result  out  2*WIDTH  ADD/SUB: {0, sum}; MUL: product; DIV: {remainder, quotient}
cout  out  1  ADD: carry out; SUB: carry of a+~b+1 (1 = no borrow, a>=b); 0 for MUL/DIV
div_by_zero  out  1  set with done when DIV with b==0; cleared on next accept

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, cout=0, div_by_zero=0.
  - Internal operand, accumulator and counter registers are all cleared.
  - Reset mid-operation aborts the operation; nothing is reported after release.
- States:
  - IDLE: start=1 accepts. Latch a, b, op; clear cout and div_by_zero. Go to RUN for MUL or DIV with b!=0; otherwise go to DONE.
  - RUN: one iteration per cycle; counter runs 0..WIDTH-1. Go to DONE after the iteration with counter=WIDTH-1.
  - DONE: done=1 for exactly this cycle; result, cout and div_by_zero updated on entry. Always returns to IDLE next cycle.
- Busy and start rules:
  - busy = (state != IDLE).
  - start while busy is ignored: no queuing, no corruption of the operation in flight.
  - Earliest back-to-back accept is the cycle after done.
- Latency (accept on edge k):
  - ADD/SUB and DIV-by-zero: done at cycle k+1.
  - MUL and DIV: done at cycle k+WIDTH+1.
- ADD/SUB:
  - Single WIDTH-bit ripple add; SUB computes a+~b+1.
  - result[2W-1:W]=0.
- MUL:
  - Unsigned shift-add. The accumulator high half adds the multiplicand when the multiplier LSB is 1, then the whole accumulator shifts right one bit.
  - Full 2*WIDTH product; never truncated.
- DIV:
  - Restoring. Each iteration shifts {rem, quo} left, trial-subtracts b from rem, keeps the difference and sets quo LSB when there is no borrow.
  - Quotient goes to result[W-1:0], remainder to result[2W-1:W].
- DIV by zero:
  - No iterations.
  - quotient = all ones, remainder = a, div_by_zero=1.
- Result hold: result holds its value until the next DONE entry. Inputs a/b/op may change freely after accept.
- Unused op encodings: none; all four are defined.

Decomposition:
- Shared package arith_pkg:
  - op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - state enum (IDLE, RUN, DONE).
- One sub-module, addsub_n: parametrised WIDTH ripple adder with a sub control that XORs b and drives carry-in.
  - Instanced once for ADD/SUB and the MUL accumulate.
  - Instanced once for the DIV trial subtract.

Test Plan:
1. WIDTH=8, ADD a=200 b=100 -> done at k+1, result=0x002C, cout=1, busy high exactly 1 cycle.
2. SUB a=5 b=9 -> result=0x00FC, cout=0. Then SUB a=9 b=5 -> result=0x0004, cout=1.
3. MUL a=255 b=255 -> done exactly at k+9, result=0xFE01, cout=0. Also MUL a=0 b=37 -> result=0x0000.
4. DIV a=200 b=7 -> done at k+9, result=0x041C (q=28, r=4), div_by_zero=0. Then DIV a=77 b=0 -> done at k+1, result=0x4DFF, div_by_zero=1.
5. MUL a=3 b=4 accepted, then start pulsed at k+3 with ADD a=1 b=1 -> ignored; result=0x000C, single done.
6. rst_n low at k+4 of a DIV -> all outputs 0 immediately (before the next clk edge), no done after release; then ADD a=1 b=2 -> result=0x0003.
